mmio_responder: RTL and testbench

//   Memory-mapped I/O responder on the processor's data port; the slave end of the bram_sdp protocol.

---
 rtl/mmio_responder.sv | 181 ++++++++++++++++++
 tb/tb_mmio_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// MMIO responder: GPIO, optional free-running timer with compare IRQ, TX byte FIFO.
// Define MMIO_TIMER_EN to build the timer, TIMER_CMP, CTRL and timer_irq.
module mmio_responder #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned GPIO_WIDTH = 8,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [3:0]            mem_mask_write,
  input  logic [ADDR_WIDTH-1:0] addr_write,
  input  logic [ADDR_WIDTH-1:0] addr_read,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  timer_irq
);

  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    REG_GPIO_OUT  = 3'd0,
    REG_GPIO_IN   = 3'd1,
    REG_TIMER     = 3'd2,
    REG_TIMER_CMP = 3'd3,
    REG_TX_DATA   = 3'd4,
    REG_STATUS    = 3'd5,
    REG_CTRL      = 3'd6
  } reg_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  logic wr_gpio, wr_tx, wr_status;
  assign wr_gpio   = write_enable && (addr_write == ADDR_WIDTH'(REG_GPIO_OUT));
  assign wr_tx     = write_enable && (addr_write == ADDR_WIDTH'(REG_TX_DATA));
  assign wr_status = write_enable && (addr_write == ADDR_WIDTH'(REG_STATUS));

  // GPIO
  logic [GPIO_WIDTH-1:0] gpio_meta, gpio_sync, gpio_next;

  always_comb begin
    gpio_next = gpio_out;
    for (int unsigned b = 0; b < GPIO_WIDTH; b++)
      if (mem_mask_write[b / 8]) gpio_next[b] = data_in[b];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out  <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      if (wr_gpio) gpio_out <= gpio_next;
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end
  end

  // Timer
  logic [31:0] timer_rd, cmp_rd, ctrl_rd;
  logic        irq_q;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer, timer_cmp;
  logic        irq_en, timer_en;
  logic        wr_timer, wr_cmp, wr_ctrl;

  assign wr_timer = write_enable && (addr_write == ADDR_WIDTH'(REG_TIMER));
  assign wr_cmp   = write_enable && (addr_write == ADDR_WIDTH'(REG_TIMER_CMP));
  assign wr_ctrl  = write_enable && (addr_write == ADDR_WIDTH'(REG_CTRL));

  always_ff @(posedge clock) begin
    if (reset) begin
      timer     <= '0;
      timer_cmp <= '1;
      irq_en    <= 1'b0;
      timer_en  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_timer)      timer <= merge_lanes(timer, data_in, mem_mask_write);
      else if (timer_en) timer <= timer + 32'd1;
      if (wr_cmp) timer_cmp <= merge_lanes(timer_cmp, data_in, mem_mask_write);
      if (wr_ctrl && mem_mask_write[0]) {irq_en, timer_en} <= data_in[1:0];
      irq_q <= irq_en && (timer >= timer_cmp);
    end
  end

  assign timer_rd = timer;
  assign cmp_rd   = timer_cmp;
  assign ctrl_rd  = {30'b0, irq_en, timer_en};
`else
  assign timer_rd = '0;
  assign cmp_rd   = '0;
  assign ctrl_rd  = '0;
  assign irq_q    = 1'b0;
  // Upper lanes only feed the timer registers; GPIO may use fewer bits.
  logic unused_lanes;
  assign unused_lanes = ^{data_in[31:8], mem_mask_write[3:1]};
`endif

  assign timer_irq = irq_q;

  // TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tx_overflow, tx_empty, tx_full;
  logic             push_req, push_ok, pop;

  assign tx_empty = (count == '0);
  assign tx_full  = (count == CNT_W'(TX_DEPTH));
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = wr_tx && mem_mask_write[0];
  assign push_ok  = push_req && (!tx_full || pop);

  always_ff @(posedge clock) begin
    if (!reset && push_ok) tx_mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A dropped push in the same cycle as a W1C keeps the flag set.
      if (push_req && tx_full && !pop)
        tx_overflow <= 1'b1;
      else if (wr_status && mem_mask_write[0] && data_in[3])
        tx_overflow <= 1'b0;
    end
  end

  // Read path
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (addr_read)
      ADDR_WIDTH'(REG_GPIO_OUT):  rd_val = 32'(gpio_out);
      ADDR_WIDTH'(REG_GPIO_IN):   rd_val = 32'(gpio_sync);
      ADDR_WIDTH'(REG_TIMER):     rd_val = timer_rd;
      ADDR_WIDTH'(REG_TIMER_CMP): rd_val = cmp_rd;
      ADDR_WIDTH'(REG_TX_DATA):   rd_val = {24'b0, 8'(count)};
      ADDR_WIDTH'(REG_STATUS):    rd_val = {28'b0, tx_overflow, irq_q, tx_full, tx_empty};
      ADDR_WIDTH'(REG_CTRL):      rd_val = ctrl_rd;
      default:                    rd_val = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)            data_out <= '0;
    else if (read_enable) data_out <= rd_val;
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed register-map scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mmio_responder;

  localparam int AW    = 3;
  localparam int GW    = 8;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          write_enable, read_enable;
  logic [3:0]    mem_mask_write;
  logic [AW-1:0] addr_write, addr_read;
  logic [31:0]   data_in, data_out;
  logic [GW-1:0] gpio_out, gpio_in;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready, timer_irq;

  always #5 clock = ~clock;

  mmio_responder #(.ADDR_WIDTH(AW), .GPIO_WIDTH(GW), .TX_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
    .mem_mask_write(mem_mask_write), .addr_write(addr_write), .addr_read(addr_read),
    .data_in(data_in), .data_out(data_out), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0]   m_dout, m_timer, m_cmp;
  logic [1:0]    m_ctrl;
  logic          m_irq, m_ovf;
  logic [GW-1:0] m_gpio;
  logic [GW-1:0] m_pins [2];  // pin values seen one and two edges ago
  byte unsigned  q[$];

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    logic full, empty;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    case (int'(a))
      0: return 32'(m_gpio);
      1: return 32'(m_pins[1]);
`ifdef MMIO_TIMER_EN
      2: return m_timer;
      3: return m_cmp;
      6: return {30'b0, m_ctrl};
`endif
      4: return 32'(q.size());
      5: return {28'b0, m_ovf, m_irq, full, empty};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_dout = '0; m_gpio = '0; m_timer = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0;
    m_irq = 1'b0; m_ovf = 1'b0; m_pins[0] = '0; m_pins[1] = '0;
    q.delete();
  endtask

  task automatic model_step();
    logic [31:0] rv;
    logic        full, pop, push, irq_n;
    if (reset) begin
      model_reset();
      return;
    end
    rv    = m_read(addr_read);
    full  = (q.size() == DEPTH);
    pop   = (q.size() > 0) && tx_ready;
    push  = write_enable && (int'(addr_write) == 4) && mem_mask_write[0];
    irq_n = m_ctrl[1] && (m_timer >= m_cmp);
    if (pop) void'(q.pop_front());
    if (push && (!full || pop)) q.push_back(data_in[7:0]);
    if (push && full && !pop) m_ovf = 1'b1;
    else if (write_enable && int'(addr_write) == 5 && mem_mask_write[0] && data_in[3]) m_ovf = 1'b0;
    if (write_enable && int'(addr_write) == 0)
      m_gpio = GW'(lanes(32'(m_gpio), data_in, mem_mask_write));
`ifdef MMIO_TIMER_EN
    if (write_enable && int'(addr_write) == 2) m_timer = lanes(m_timer, data_in, mem_mask_write);
    else if (m_ctrl[0]) m_timer = m_timer + 1;
    if (write_enable && int'(addr_write) == 3) m_cmp = lanes(m_cmp, data_in, mem_mask_write);
    if (write_enable && int'(addr_write) == 6 && mem_mask_write[0]) m_ctrl = data_in[1:0];
    m_irq = irq_n;
`else
    irq_n = 1'b0;
    m_irq = irq_n;
`endif
    m_pins[1] = m_pins[0];
    m_pins[0] = gpio_in;
    if (read_enable) m_dout = rv;
  endtask

  task automatic compare_all();
    check_eq("data_out", data_out, m_dout);
    check_eq("gpio_out", 32'(gpio_out), 32'(m_gpio));
    check_eq("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(q[0]));
    check_eq("timer_irq", 32'(timer_irq), 32'(m_irq));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] m);
    write_enable = 1'b1; addr_write = AW'(a); data_in = d; mem_mask_write = m;
    cycle();
    write_enable = 1'b0;
  endtask

  task automatic rd_expect(input int a, input logic [31:0] exp, input string tag);
    read_enable = 1'b1; addr_read = AW'(a);
    cycle();
    read_enable = 1'b0;
    check_eq(tag, data_out, exp);
  endtask

  logic [31:0] rst_exp [8];
  int          n;

  initial begin
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0; mem_mask_write = '0;
    addr_write = '0; addr_read = '0; data_in = '0; gpio_in = '0; tx_ready = 1'b0;
    model_reset();
    idle(2);
    reset = 1'b0;

    // Reset values of every offset
`ifdef MMIO_TIMER_EN
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 32'h0};
`else
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
`endif
    for (int i = 0; i < 8; i++) rd_expect(i, rst_exp[i], $sformatf("reset_rd%0d", i));

    // Masked GPIO write with same-cycle read of the old value
    write_enable = 1'b1; addr_write = '0; data_in = 32'hA5A5_A5A5; mem_mask_write = 4'b0001;
    read_enable = 1'b1; addr_read = '0;
    cycle();
    write_enable = 1'b0; read_enable = 1'b0;
    check_eq("gpio_same_cycle_rd", data_out, 32'h0);
    check_eq("gpio_out_a5", 32'(gpio_out), 32'hA5);
    rd_expect(0, 32'h0000_00A5, "gpio_rd_a5");

    // GPIO input synchronizer
    gpio_in = 8'h3C;
    idle(2);
    rd_expect(1, 32'h3C, "gpio_in_sync");

`ifdef MMIO_TIMER_EN
    wr(3, 32'd10, 4'hF);
    wr(2, 32'd0, 4'hF);
    wr(6, 32'd3, 4'h1);
    n = 0;
    while (!timer_irq && n < 40) begin cycle(); n++; end
    check_eq("irq_latency", 32'(n), 32'd11);
    rd_expect(2, 32'd11, "timer_at_irq");
    wr(2, 32'hFFFF_FFFE, 4'hF);
    idle(2);
    rd_expect(2, 32'h0, "timer_wrap");
    wr(6, 32'd0, 4'h1);
    idle(1);
`else
    wr(2, 32'h1234_5678, 4'hF);
    rd_expect(2, 32'h0, "timer_absent");
    wr(6, 32'h3, 4'hF);
    rd_expect(6, 32'h0, "ctrl_absent");
    check_eq("irq_tied", 32'(timer_irq), 32'h0);
`endif

    // Fill past full, then drain in order
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(4, 32'(i), 4'h1);
    rd_expect(5, 32'hA, "status_full_ovf");
    rd_expect(4, 32'd8, "count_full");
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_valid", 32'(tx_valid), 32'h1);
      check_eq("drain_data", 32'(tx_data), 32'(i));
      cycle();
    end
    check_eq("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    wr(5, 32'h8, 4'h1);
    rd_expect(5, 32'h1, "ovf_cleared");

    // Push while full with a simultaneous pop
    for (int i = 0; i < 8; i++) wr(4, 32'h11 + 32'(i), 4'h1);
    tx_ready = 1'b1;
    wr(4, 32'h55, 4'h1);
    tx_ready = 1'b0;
    rd_expect(4, 32'd8, "full_pop_push_count");
    rd_expect(5, 32'h2, "full_pop_push_status");
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("pp_data", 32'(tx_data), (i == 7) ? 32'h55 : 32'h12 + 32'(i));
      cycle();
    end
    check_eq("pp_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Reset with bytes queued
    for (int i = 0; i < 4; i++) wr(4, 32'hA0 + 32'(i), 4'h1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    rd_expect(4, 32'h0, "rst_count");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      write_enable   = $urandom_range(0, 1) == 1;
      addr_write     = ($urandom_range(0, 9) < 4) ? AW'(4) : AW'($urandom);
      data_in        = $urandom;
      mem_mask_write = 4'($urandom);
      read_enable    = $urandom_range(0, 1) == 1;
      addr_read      = AW'($urandom);
      gpio_in        = GW'($urandom);
      tx_ready       = $urandom_range(0, 2) == 0;
      cycle();
    end
    reset = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
